// File: rtl/instruction_control_fsm.sv
// instruction_control_fsm: multi-cycle IF/ID/EX/MEM/WB control sequencer.
// Steps each instruction through only the stages its class needs. It waits on
// the mem_ready handshake during fetch and data access, and aborts to IF after a
// bounded wait.
// The strobe outputs are decoded from the current state. They are valid in the
// same cycle that stage reports the state, because the ID strobes depend on
// opcode_type, which is only valid while the FSM sits in ID.

module instruction_control_fsm #(
   parameter int unsigned INSTR_WIDTH  = 16,
   parameter int unsigned STAGE_WIDTH  = 3,
   parameter int unsigned MEM_TIMEOUT  = 15,
   parameter int unsigned OPCODE_COUNT = 5,
   parameter int unsigned SIGNAL_COUNT = 9
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [OPCODE_COUNT-1:0] opcode_type,
   input  logic                    mem_ready,
   output logic [SIGNAL_COUNT-1:0] signals,
   output logic [STAGE_WIDTH-1:0]  stage,
   output logic                    ir_load,
   output logic                    pc_inc,
   output logic                    illegal_instr,
   output logic                    timeout
);

   // Instruction class bit positions in opcode_type
   localparam int unsigned OPC_ALU_RR  = 0;
   localparam int unsigned OPC_ALU_IMM = 1;
   localparam int unsigned OPC_LOAD    = 2;
   localparam int unsigned OPC_STORE   = 3;
   localparam int unsigned OPC_NOP     = 4;

   // Control strobe bit positions in signals
   localparam int unsigned CONTROL_MEM_INSTR_READ = 0;
   localparam int unsigned CONTROL_RR_READ        = 1;
   localparam int unsigned CONTROL_RD_READ        = 2;
   localparam int unsigned CONTROL_ALU_ENABLE     = 3;
   localparam int unsigned CONTROL_ADDR_CALC      = 4;
   localparam int unsigned CONTROL_MEM_DATA_READ  = 5;
   localparam int unsigned CONTROL_MEM_DATA_WRITE = 6;
   localparam int unsigned CONTROL_REG_RD_WRITE   = 7;
   localparam int unsigned CONTROL_WB_SEL_MEM     = 8;

   // State encoding, visible on the stage port
   localparam logic [STAGE_WIDTH-1:0] ST_RESET = STAGE_WIDTH'(0);
   localparam logic [STAGE_WIDTH-1:0] ST_IF    = STAGE_WIDTH'(1);
   localparam logic [STAGE_WIDTH-1:0] ST_ID    = STAGE_WIDTH'(2);
   localparam logic [STAGE_WIDTH-1:0] ST_EX    = STAGE_WIDTH'(3);
   localparam logic [STAGE_WIDTH-1:0] ST_MEM   = STAGE_WIDTH'(4);
   localparam logic [STAGE_WIDTH-1:0] ST_WB    = STAGE_WIDTH'(5);

   // Memory wait counter sizing; the counter never needs to exceed MEM_TIMEOUT
   localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   // Elaboration-time sanity checks on the parameter set
   if (INSTR_WIDTH == 0) begin : g_bad_instr_width
      $error("instruction_control_fsm: INSTR_WIDTH must be non-zero");
   end
   if (STAGE_WIDTH < 3) begin : g_bad_stage_width
      $error("instruction_control_fsm: STAGE_WIDTH must be at least 3");
   end
   if (MEM_TIMEOUT == 0) begin : g_bad_timeout
      $error("instruction_control_fsm: MEM_TIMEOUT must be non-zero");
   end
   if (OPCODE_COUNT != 5) begin : g_bad_opcode_count
      $error("instruction_control_fsm: OPCODE_COUNT must be 5");
   end
   if (SIGNAL_COUNT != 9) begin : g_bad_signal_count
      $error("instruction_control_fsm: SIGNAL_COUNT must be 9");
   end

   logic [STAGE_WIDTH-1:0] state;
   logic [STAGE_WIDTH-1:0] state_nxt;
   logic [WAIT_W-1:0]      wait_cnt;
   logic [WAIT_W-1:0]      wait_cnt_nxt;
   logic [WAIT_W-1:0]      wait_cnt_inc;
   logic                   wait_at_limit;

   // Class latched at the end of ID; EX/MEM/WB ignore later opcode_type changes
   logic                   cls_alu_q;
   logic                   cls_load_q;
   logic                   cls_store_q;
   logic                   cls_alu_nxt;
   logic                   cls_load_nxt;
   logic                   cls_store_nxt;

   logic                   opcode_legal;
   logic                   id_alu;
   logic                   id_load;
   logic                   id_store;

   // Decode of the live opcode; meaningful only while in ID
   always_comb begin
      opcode_legal = $onehot(opcode_type);
      id_alu       = opcode_legal & (opcode_type[OPC_ALU_RR] | opcode_type[OPC_ALU_IMM]);
      id_load      = opcode_legal & opcode_type[OPC_LOAD];
      id_store     = opcode_legal & opcode_type[OPC_STORE];
   end

   // Saturating increment of the memory wait counter
   always_comb begin
      wait_at_limit = (wait_cnt == WAIT_MAX);
      wait_cnt_inc  = wait_at_limit ? wait_cnt : wait_cnt + WAIT_W'(1);
   end

   // State, wait counter and latched class registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_RESET;
         wait_cnt    <= '0;
         cls_alu_q   <= 1'b0;
         cls_load_q  <= 1'b0;
         cls_store_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         cls_alu_q   <= cls_alu_nxt;
         cls_load_q  <= cls_load_nxt;
         cls_store_q <= cls_store_nxt;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = '0;
      cls_alu_nxt   = cls_alu_q;
      cls_load_nxt  = cls_load_q;
      cls_store_nxt = cls_store_q;
      signals       = '0;
      ir_load       = 1'b0;
      pc_inc        = 1'b0;
      illegal_instr = 1'b0;
      timeout       = 1'b0;

      case (state)
         ST_RESET: begin
            state_nxt = ST_IF;
         end

         ST_IF: begin
            signals[CONTROL_MEM_INSTR_READ] = 1'b1;
            if (mem_ready) begin
               ir_load   = 1'b1;
               pc_inc    = 1'b1;
               state_nxt = ST_ID;
            end else if (wait_at_limit) begin
               // Re-entering IF clears the counter and refetches
               timeout   = 1'b1;
               state_nxt = ST_IF;
            end else begin
               wait_cnt_nxt = wait_cnt_inc;
            end
         end

         ST_ID: begin
            illegal_instr = ~opcode_legal;
            cls_alu_nxt   = id_alu;
            cls_load_nxt  = id_load;
            cls_store_nxt = id_store;
            if (opcode_legal) begin
               if (opcode_type[OPC_ALU_RR]) begin
                  signals[CONTROL_RR_READ] = 1'b1;
                  signals[CONTROL_RD_READ] = 1'b1;
               end
               if (opcode_type[OPC_ALU_IMM]) begin
                  signals[CONTROL_RD_READ] = 1'b1;
               end
               if (opcode_type[OPC_LOAD]) begin
                  signals[CONTROL_RR_READ] = 1'b1;
               end
               if (opcode_type[OPC_STORE]) begin
                  signals[CONTROL_RR_READ] = 1'b1;
                  signals[CONTROL_RD_READ] = 1'b1;
               end
            end
            // NOP and illegal encodings both return straight to fetch
            state_nxt = (id_alu | id_load | id_store) ? ST_EX : ST_IF;
         end

         ST_EX: begin
            if (cls_alu_q) begin
               signals[CONTROL_ALU_ENABLE] = 1'b1;
               state_nxt = ST_WB;
            end else if (cls_load_q | cls_store_q) begin
               signals[CONTROL_ADDR_CALC] = 1'b1;
               state_nxt = ST_MEM;
            end else begin
               state_nxt = ST_IF;
            end
         end

         ST_MEM: begin
            signals[CONTROL_MEM_DATA_READ]  = cls_load_q;
            signals[CONTROL_MEM_DATA_WRITE] = cls_store_q;
            if (mem_ready) begin
               // A ready on the limit cycle still counts as success
               state_nxt = cls_load_q ? ST_WB : ST_IF;
            end else if (wait_at_limit) begin
               // Abandon the access; a pending LOAD never reaches WB
               timeout   = 1'b1;
               state_nxt = ST_IF;
            end else begin
               wait_cnt_nxt = wait_cnt_inc;
            end
         end

         ST_WB: begin
            signals[CONTROL_REG_RD_WRITE] = 1'b1;
            signals[CONTROL_WB_SEL_MEM]   = cls_load_q;
            state_nxt = ST_IF;
         end

         default: begin
            state_nxt = ST_IF;
         end
      endcase
   end

   assign stage = state;

endmodule

// File: doc/instruction_control_fsm.md
Name: instruction_control_fsm

Overview:
- Multi-cycle control sequencer that drives the `signals` bus consumed by the register-file interface unit and the ALU/memory datapath.
- Steps each instruction through IF -> ID -> EX -> MEM -> WB and skips stages the instruction does not need.
- Waits on a memory ready handshake during fetch and data access.
- Sits between the instruction decoder (source of `opcode_type`) and the datapath stages.

Parameters:
- INSTR_WIDTH, 16, instruction width in bits.
- STAGE_WIDTH, 3, width of the state/stage encoding.
- MEM_TIMEOUT, 15, maximum mem_ready wait cycles before the FSM aborts to IF.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode_type  input  `OPCODE_COUNT  one-hot instruction class from the decoder; valid from ID onward.
- mem_ready  input  1  memory completes the current IF/MEM access this cycle.
- signals  output  `SIGNAL_COUNT  one-hot-per-bit control strobes, indexed by `CONTROL_*` macros in defines.vh.
- stage  output  STAGE_WIDTH  current state: RESET=0, IF=1, ID=2, EX=3, MEM=4, WB=5.
- ir_load  output  1  load the instruction register (IF completion cycle).
- pc_inc  output  1  increment the PC (same cycle as ir_load).
- illegal_instr  output  1  one-cycle pulse, in ID, when opcode_type is not exactly one-hot among known classes.
- timeout  output  1  one-cycle pulse when a memory wait exceeds MEM_TIMEOUT.

Behaviour:
- Reset (synchronous):
  - state=RESET, wait counter=0.
  - signals, ir_load, pc_inc, illegal_instr and timeout all 0.
  - The cycle after reset deasserts, state=IF.
  - Reset asserted mid-instruction takes effect on the next edge and drops all strobes; an in-flight RD_WRITE is suppressed.
- IF:
  - Assert `CONTROL_MEM_INSTR_READ`.
  - Stay in IF while mem_ready=0.
  - The cycle mem_ready=1: ir_load=pc_inc=1 (one cycle), next state=ID.
- ID: assert strobes by class.
  - ALU_RR: RR_READ and RD_READ.
  - ALU_IMM: RD_READ only.
  - LOAD: RR_READ (address register).
  - STORE: RR_READ and RD_READ.
  - NOP: none.
  - Next state: NOP or illegal -> IF; all other classes -> EX.
- EX:
  - Assert `CONTROL_ALU_ENABLE` for ALU_RR/ALU_IMM, `CONTROL_ADDR_CALC` for LOAD/STORE.
  - Next state: ALU -> WB, LOAD/STORE -> MEM.
- MEM:
  - LOAD asserts `CONTROL_MEM_DATA_READ`; STORE asserts `CONTROL_MEM_DATA_WRITE`.
  - Hold while mem_ready=0.
  - On mem_ready=1: LOAD -> WB, STORE -> IF.
- WB:
  - Assert `CONTROL_REG_RD_WRITE` for exactly one cycle.
  - `CONTROL_WB_SEL_MEM`=1 for LOAD, 0 for ALU.
  - Next state=IF.
- Class latching:
  - opcode_type is sampled and latched at the end of ID.
  - EX/MEM/WB use the latched class; input changes after ID are ignored.
- Strobe rules:
  - RD_READ and RD_WRITE are never both asserted.
  - Any strobe not listed for the current state is 0 (never X).
- Memory wait counter:
  - Clears on entry to IF/MEM and increments each cycle with mem_ready=0.
  - At count==MEM_TIMEOUT with mem_ready still 0: timeout pulses 1 cycle and state -> IF. PC is not incremented and WB is not performed.
  - mem_ready=1 on the same cycle as count==MEM_TIMEOUT counts as success.
  - The counter saturates and never wraps.
- Illegal instruction: illegal_instr pulses in ID; the instruction is treated as NOP.
- Latencies with mem_ready tied high:
  - ALU: 4 cycles (IF, ID, EX, WB).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - NOP: 2 cycles.

Test Plan:
- Reset held 3 cycles, mem_ready=1, ALU_RR stream -> stage sequence 0,1,2,3,5,1,…; RR_READ+RD_READ only in ID; RD_WRITE exactly 1 cycle in WB; ir_load pulses every 4 cycles.
- LOAD with mem_ready low 2 cycles in MEM -> MEM held 3 cycles; WB_SEL_MEM=1 with RD_WRITE in WB; total 7 cycles IF-to-IF.
- STORE -> MEM_DATA_WRITE in MEM, no RD_WRITE; return to IF after mem_ready.
- mem_ready stuck 0 in IF for 16+ cycles -> timeout pulses once after 15 wait cycles; pc_inc never asserted; FSM re-enters IF.
- opcode_type=0 (and separately two bits set) in ID -> illegal_instr 1-cycle pulse; next stage IF; no strobes in EX/WB.
- reset asserted during WB of an ALU_RR -> RD_WRITE 0 on the following cycle; stage=0, then IF.
